// File: rtl/rpe_pkg.sv
// Shared definitions for the reduced-precision weight-stationary PE family.
// Holds the default widths, the index of the weight mode bit and the
// weight-code decoder used by every PE variant.
//
// Contents:
//   ACT_W_DEF, WMAG_W_DEF, NMSR_SHIFT_DEF, PSUM_W_DEF : default widths
//   MODE_BIT_DEF : bit position of the mode bit M within a default weight code
//   decode_weight : compressed weight code -> signed effective weight
package rpe_pkg;

    localparam int ACT_W_DEF      = 7;
    localparam int WMAG_W_DEF     = 4;
    localparam int NMSR_SHIFT_DEF = 4;
    localparam int PSUM_W_DEF     = 2 * (ACT_W_DEF + 1) + 3;

    // The mode bit sits directly above the signed value field.
    localparam int MODE_BIT_DEF   = WMAG_W_DEF;

    // Decode a weight code given its mode bit and its sign-extended value
    // field. Mode 0 gives odd weights 2s+1. Mode 1 gives a shifted weight
    // whose negative side is ones-complement, so s=-1 encodes zero.
    function automatic logic signed [31:0] decode_weight(
        input logic               mode,
        input logic signed [31:0] mag,
        input int unsigned        shift
    );
        logic signed [31:0] weff;
        if (!mode) begin
            weff = (mag <<< 1) + 32'sd1;
        end else if (!mag[31]) begin
            weff = mag <<< shift;
        end else begin
            weff = (mag + 32'sd1) <<< shift;
        end
        return weff;
    endfunction

endpackage

// File: rtl/rpe_dbuf_if.sv
// Bundle of the column/row signals of one double-buffered PE.
//
// Signals:
//   w_in, w_in_valid, w_swap_in      : weight chain from the PE above
//   w_out, w_out_valid, w_swap_out   : weight chain to the PE below
//   act_in, act_in_valid, psum_in    : activation / partial-sum wavefront in
//   act_out, act_out_valid           : activation to the PE on the right
//   psum_out, psum_out_valid         : partial sum to the PE below
//   w_active_valid, w_shadow_valid   : weight buffer status
// Modports: slave = the PE itself, master = whatever drives the PE.
interface rpe_dbuf_if
    import rpe_pkg::*;
#(
    parameter int ACT_W  = ACT_W_DEF,
    parameter int WMAG_W = WMAG_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF
) ();

    logic [WMAG_W:0]   w_in;
    logic              w_in_valid;
    logic [WMAG_W:0]   w_out;
    logic              w_out_valid;
    logic              w_swap_in;
    logic              w_swap_out;
    logic [ACT_W-1:0]  act_in;
    logic              act_in_valid;
    logic [ACT_W-1:0]  act_out;
    logic              act_out_valid;
    logic [PSUM_W-1:0] psum_in;
    logic [PSUM_W-1:0] psum_out;
    logic              psum_out_valid;
    logic              w_active_valid;
    logic              w_shadow_valid;

    modport slave (
        input  w_in, w_in_valid, w_swap_in, act_in, act_in_valid, psum_in,
        output w_out, w_out_valid, w_swap_out, act_out, act_out_valid,
               psum_out, psum_out_valid, w_active_valid, w_shadow_valid
    );

    modport master (
        output w_in, w_in_valid, w_swap_in, act_in, act_in_valid, psum_in,
        input  w_out, w_out_valid, w_swap_out, act_out, act_out_valid,
               psum_out, psum_out_valid, w_active_valid, w_shadow_valid
    );

endinterface

// File: rtl/rpe_mac.sv
// Combinational multiply-accumulate of one PE: decodes the weight code,
// multiplies by the effective activation at full precision and adds the
// sign-extended product to the incoming partial sum, wrapping to PSUM_W.
//
// Ports:
//   a_i          : effective signed activation, ACT_W+1 bits
//   w_code_i     : compressed weight code, WMAG_W+1 bits (MSB = mode)
//   psum_in_i    : incoming partial sum
//   psum_next_o  : psum_in_i + A*Weff modulo 2^PSUM_W
module rpe_mac
    import rpe_pkg::*;
#(
    parameter int ACT_W      = ACT_W_DEF,
    parameter int WMAG_W     = WMAG_W_DEF,
    parameter int NMSR_SHIFT = NMSR_SHIFT_DEF,
    parameter int PSUM_W     = PSUM_W_DEF
) (
    input  logic signed [ACT_W:0]  a_i,
    input  logic [WMAG_W:0]        w_code_i,
    input  logic [PSUM_W-1:0]      psum_in_i,
    output logic [PSUM_W-1:0]      psum_next_o
);

    // Wide enough for both 2s+1 and the shifted mode-1 weight.
    localparam int WEFF_W = WMAG_W + NMSR_SHIFT + 1;
    localparam int PROD_W = ACT_W + 1 + WEFF_W;
    localparam int SUM_W  = (PROD_W > PSUM_W) ? PROD_W : PSUM_W;

    logic signed [WMAG_W-1:0] magField;
    logic signed [31:0]       magExt;
    logic signed [WEFF_W-1:0] weff;
    logic signed [PROD_W-1:0] prod;
    logic [SUM_W-1:0]         sumWide;

    assign magField = signed'(w_code_i[WMAG_W-1:0]);
    assign magExt   = 32'(magField);
    assign weff     = WEFF_W'(decode_weight(w_code_i[WMAG_W], magExt, NMSR_SHIFT));

    // Operands are widened first so the product is never truncated.
    assign prod        = PROD_W'(a_i) * PROD_W'(weff);
    assign sumWide     = SUM_W'(prod) + SUM_W'(psum_in_i);
    assign psum_next_o = sumWide[PSUM_W-1:0];

endmodule

// File: rtl/rpe_dbuf.sv
// Weight-stationary PE with double-buffered weights. A new weight tile
// shifts down the column into the shadow register while the active weight
// keeps computing; a swap pulse travelling down the column promotes the
// shadow weight to active one row per cycle.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rpe_dbuf_if slave modport (weight chain, activation/psum
//          wavefront and weight buffer status)
module rpe_dbuf
    import rpe_pkg::*;
#(
    parameter int ACT_W      = ACT_W_DEF,
    parameter int WMAG_W     = WMAG_W_DEF,
    parameter int NMSR_SHIFT = NMSR_SHIFT_DEF,
    parameter int PSUM_W     = PSUM_W_DEF
) (
    input logic       clk,
    input logic       rst,
    rpe_dbuf_if.slave bus
);

    logic [WMAG_W:0]   wOut_q, wOut_d;
    logic              wOutValid_q, wOutValid_d;
    logic              wSwapOut_q, wSwapOut_d;
    logic [WMAG_W:0]   wShadow_q, wShadow_d;
    logic              shadowValid_q, shadowValid_d;
    logic [WMAG_W:0]   wActive_q, wActive_d;
    logic              activeValid_q, activeValid_d;
    logic [ACT_W-1:0]  actOut_q, actOut_d;
    logic              actOutValid_q, actOutValid_d;
    logic [PSUM_W-1:0] psumOut_q, psumOut_d;
    logic              psumOutValid_q, psumOutValid_d;

    logic signed [ACT_W:0] actEff;
    logic [PSUM_W-1:0]     macNext;

    // Stored activations carry an implicit LSB of one.
    assign actEff = {bus.act_in, 1'b1};

    rpe_mac #(
        .ACT_W      (ACT_W),
        .WMAG_W     (WMAG_W),
        .NMSR_SHIFT (NMSR_SHIFT),
        .PSUM_W     (PSUM_W)
    ) uMac (
        .a_i         (actEff),
        .w_code_i    (wActive_q),
        .psum_in_i   (bus.psum_in),
        .psum_next_o (macNext)
    );

    // Next-state logic. The swap reads the shadow before this cycle's load
    // overwrites it, so a simultaneous swap+load promotes the old shadow and
    // leaves the new weight waiting. The MAC always sees the pre-edge active
    // weight, so a swap only affects the following cycle.
    always_comb begin
        wOut_d         = bus.w_in;
        wOutValid_d    = bus.w_in_valid;
        wSwapOut_d     = bus.w_swap_in;
        wShadow_d      = wShadow_q;
        shadowValid_d  = shadowValid_q;
        wActive_d      = wActive_q;
        activeValid_d  = activeValid_q;
        actOut_d       = actOut_q;
        psumOut_d      = psumOut_q;
        actOutValid_d  = bus.act_in_valid;
        psumOutValid_d = bus.act_in_valid;

        if (bus.w_swap_in && shadowValid_q) begin
            wActive_d     = wShadow_q;
            activeValid_d = 1'b1;
            shadowValid_d = 1'b0;
        end
        if (bus.w_in_valid) begin
            wShadow_d     = bus.w_in;
            shadowValid_d = 1'b1;
        end

        if (bus.act_in_valid) begin
            actOut_d  = bus.act_in;
            psumOut_d = activeValid_q ? macNext : bus.psum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wOut_q         <= '0;
            wOutValid_q    <= 1'b0;
            wSwapOut_q     <= 1'b0;
            wShadow_q      <= '0;
            shadowValid_q  <= 1'b0;
            wActive_q      <= '0;
            activeValid_q  <= 1'b0;
            actOut_q       <= '0;
            actOutValid_q  <= 1'b0;
            psumOut_q      <= '0;
            psumOutValid_q <= 1'b0;
        end else begin
            wOut_q         <= wOut_d;
            wOutValid_q    <= wOutValid_d;
            wSwapOut_q     <= wSwapOut_d;
            wShadow_q      <= wShadow_d;
            shadowValid_q  <= shadowValid_d;
            wActive_q      <= wActive_d;
            activeValid_q  <= activeValid_d;
            actOut_q       <= actOut_d;
            actOutValid_q  <= actOutValid_d;
            psumOut_q      <= psumOut_d;
            psumOutValid_q <= psumOutValid_d;
        end
    end

    assign bus.w_out          = wOut_q;
    assign bus.w_out_valid    = wOutValid_q;
    assign bus.w_swap_out     = wSwapOut_q;
    assign bus.act_out        = actOut_q;
    assign bus.act_out_valid  = actOutValid_q;
    assign bus.psum_out       = psumOut_q;
    assign bus.psum_out_valid = psumOutValid_q;
    assign bus.w_active_valid = activeValid_q;
    assign bus.w_shadow_valid = shadowValid_q;

endmodule
